// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM encoding,
// indices into the adder cell output and the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int SUM_BIT       = 0;
  localparam int CARRY_BIT     = 1;

  // Bit counter width for a given operand width (2..32 gives 1..5 bits).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// The slave modport is the adder; the master modport is its environment.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start_valid,
    input  start_ready,
    output op_a,
    output op_b,
    output carry_in,
    input  done_valid,
    output done_ready,
    input  result,
    input  carry_out
  );

  modport slave (
    input  start_valid,
    output start_ready,
    input  op_a,
    input  op_b,
    input  carry_in,
    output done_valid,
    input  done_ready,
    output result,
    output carry_out
  );

endinterface

// File: rtl/serial_adder_cell.sv
// The team's 3-input/2-bit adder cell: y = a + b + c, purely combinational.
module add_bit_cell (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic [1:0] y_o
);

  assign y_o = {1'b0, a_i} + {1'b0, b_i} + {1'b0, c_i};

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add stage: accepts two operands plus carry, adds one bit pair
// per cycle through add_bit_cell, and holds the sum until it is taken.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             carry_out_q, carry_out_d;

  logic [1:0] cell_y;
  logic       last_bit;

  add_bit_cell u_cell (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .y_o (cell_y)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start_valid) state_d = RUN;
      RUN:  if (last_bit)        state_d = DONE;
      DONE: if (bus.done_ready)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.start_ready = 1'b0;
    bus.done_valid  = 1'b0;
    unique case (state_q)
      IDLE:    bus.start_ready = 1'b1;
      DONE:    bus.done_valid  = 1'b1;
      default: ;
    endcase
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;

  // ---------------------------------------------------------------------
  // Datapath: operand shifters, running carry, result assembly
  // ---------------------------------------------------------------------
  always_comb begin
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_sr_d   = bus.op_a;
          b_sr_d   = bus.op_b;
          carry_d  = bus.carry_in;
          cnt_d    = '0;
          result_d = '0;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH edges.
        result_d = {cell_y[SUM_BIT], result_q[WIDTH-1:1]};
        carry_d  = cell_y[CARRY_BIT];
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          carry_out_d = cell_y[CARRY_BIT];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, handshaked add stage built around the team's 3-input/2-bit adder cell.
- Upstream side: accepts two WIDTH-bit operands plus a carry-in.
- Each cycle it presents one operand bit pair and the running carry (a, b, c) to the cell. It consumes the cell's 2-bit {carry, sum} output and assembles the full sum LSB-first.
- The finished sum is held until the downstream consumer takes it.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_valid  input  1  operands and carry_in valid
- start_ready  output  1  block can accept operands (high only in IDLE)
- op_a  input  WIDTH  operand A, sampled on accept
- op_b  input  WIDTH  operand B, sampled on accept
- carry_in  input  1  initial carry, sampled on accept
- done_valid  output  1  result/carry_out valid (high only in DONE)
- done_ready  input  1  downstream takes result
- result  output  WIDTH  sum bits, op_a+op_b+carry_in mod 2^WIDTH
- carry_out  output  1  final carry of the sum

Behaviour:
- Reset (asynchronous, active-low; immediate on rst_n low, any state including mid-RUN):
  - state=IDLE; start_ready=1 once reset is released.
  - done_valid=0, result=0, carry_out=0.
  - Bit counter, operand shift registers and carry register all cleared.
  - An in-flight add is discarded; nothing is reported for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start_ready=1. On an edge with start_valid=1:
    - load op_a, op_b into shift registers; carry register <= carry_in.
    - counter <= 0; clear result; go to RUN.
    - start_valid=0: stay in IDLE.
  - RUN (start_ready=0, done_valid=0), per edge:
    - Cell inputs: a=A_sr[0], b=B_sr[0], c=carry_reg.
    - Cell output y[1:0] = a+b+c (0..3); y[0]=sum bit, y[1]=carry.
    - result <= {y[0], result[WIDTH-1:1]}; carry_reg <= y[1].
    - A_sr, B_sr shift right by 1 with zero fill; counter++.
    - When counter==WIDTH-1, this edge processes the last bit: go to DONE; carry_out <= y[1].
  - DONE: done_valid=1; result and carry_out held stable.
    - On an edge with done_ready=1: go to IDLE (done_valid drops; result/carry_out stay held).
    - done_ready=0: hold indefinitely.
- Latency: the accept edge is E0. RUN covers WIDTH edges, and done_valid rises after edge E(WIDTH). Minimum issue interval is WIDTH+2 cycles.
- No overlap: a start_valid asserted during RUN or DONE is ignored. It is only accepted on the first IDLE edge, so acceptance can never coincide with a done handshake.
- Inputs op_a, op_b and carry_in may change freely after the accept edge.
- Counter width: $clog2(WIDTH). All arithmetic is within the 1-bit cell; no wide adder is inferred.
- Wrap-around: overflow beyond WIDTH bits appears only on carry_out; result is the modulo sum.

Decomposition:
- Package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE) as logic [1:0]
  - localparam for counter width
  - SUM_BIT=0, CARRY_BIT=1 index constants for the cell output
- One sub-module, add_bit_cell:
  - combinational, inputs a, b, c; output y[1:0] = a+b+c.
  - Instantiated once and driven by the FSM datapath.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> result=0, carry_out=0, done_valid=0. After release: start_ready=1, state IDLE.
- 0x3C+0x05, carry_in=0 -> done_valid high exactly 8 cycles after the accept edge; result=0x41, carry_out=0. With done_ready=1, IDLE on the next edge.
- Wrap: 0xFF+0x01, carry_in=0 -> result=0x00, carry_out=1. Also 0xFF+0xFF, carry_in=1 -> result=0xFF, carry_out=1.
- Backpressure: hold done_ready=0 for 5 cycles after done_valid with start_valid=1 and new operands -> result/carry_out stable, start_ready=0, new operands ignored. After done_ready pulse, the next add is accepted in IDLE and yields the correct new sum.
- Reset mid-RUN: assert rst_n low after the 3rd RUN edge of 0xAA+0x55 -> outputs zero immediately, IDLE. A following 0x12+0x34, carry_in=1 gives result=0x47, carry_out=0.
- Exhaustive cell check: sweep {a,b,c} = 0..7 into add_bit_cell -> y = 0,1,1,2,1,2,2,3.
